// File: rtl/weights_ram_reader.sv
// Sequential reader for a synchronous-read weights RAM.
// Streams words over valid/ready through a 2-entry buffer with credit-based issue.
module weights_ram_reader #(
    parameter int unsigned RAM_DEPTH  = 8,
    parameter int unsigned ADDR_BITS  = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  start_addr,
    input  logic [ADDR_BITS:0]    len,
    output logic                  rd_en,
    output logic [ADDR_BITS-1:0]  rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned CNT_W = ADDR_BITS + 1;
    localparam logic [ADDR_BITS-1:0] ADDR_MAX = ADDR_BITS'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      issued;
    logic [CNT_W-1:0]      pushed;
    logic                  inflight;
    logic                  v0;
    logic                  v1;
    logic                  l0;
    logic                  l1;
    logic [DATA_WIDTH-1:0] d0;
    logic [DATA_WIDTH-1:0] d1;
    logic                  pop;
    logic                  push;
    logic                  push_last;
    logic                  accept;
    logic [2:0]            occ_load;

    // Slot 0 is the head of the buffer and drives the output directly.
    assign out_valid = v0;
    assign out_data  = d0;
    assign out_last  = l0;

    assign pop       = v0 & out_ready;
    assign push      = inflight;
    assign push_last = (pushed + CNT_W'(1)) == len_q;
    assign accept    = start & (state == S_IDLE);
    assign occ_load  = 3'(v0) + 3'(v1) + 3'(inflight);

    // A slot freed by a pop this cycle can be reused by a read issued this cycle.
    assign rd_en = (state == S_RUN) && (issued < len_q) && (occ_load < (3'd2 + 3'(pop)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = (len == '0) ? S_FIN : S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (pop && l0) state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address generation and transfer counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            len_q    <= '0;
            rd_addr  <= '0;
            issued   <= '0;
            pushed   <= '0;
        end else begin
            inflight <= rd_en;
            if (accept) begin
                len_q   <= len;
                rd_addr <= start_addr;
                issued  <= '0;
            end else if (rd_en) begin
                rd_addr <= (rd_addr == ADDR_MAX) ? '0 : rd_addr + ADDR_BITS'(1);
                issued  <= issued + CNT_W'(1);
            end
            if (accept)    pushed <= '0;
            else if (push) pushed <= pushed + CNT_W'(1);
        end
    end

    // Two-slot FIFO: returning RAM data enters the lowest free slot, pops shift down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            l0 <= 1'b0;
            l1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!v0) begin
                        v0 <= 1'b1;
                        d0 <= rd_data;
                        l0 <= push_last;
                    end else begin
                        v1 <= 1'b1;
                        d1 <= rd_data;
                        l1 <= push_last;
                    end
                end
                2'b01: begin
                    v0 <= v1;
                    d0 <= d1;
                    l0 <= l1;
                    v1 <= 1'b0;
                    l1 <= 1'b0;
                end
                2'b11: begin
                    if (!v1) begin
                        d0 <= rd_data;
                        l0 <= push_last;
                    end else begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= rd_data;
                        l1 <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_weights_ram_reader.sv
// Randomized self-checking bench for weights_ram_reader against a transfer-level model.
module tb_weights_ram_reader;
    localparam int unsigned RAM_DEPTH  = 8;
    localparam int unsigned ADDR_BITS  = 3;
    localparam int unsigned DATA_WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_BITS-1:0]  start_addr;
    logic [ADDR_BITS:0]    len;
    logic                  rd_en;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0] rd_data = '0;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    weights_ram_reader #(
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .len       (len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Synchronous-read RAM, one cycle latency.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int a);
        return 32'(8'h10 + 8'(a % RAM_DEPTH));
    endfunction

    // mode 0: always ready, 1: 1,0,0,1,0,1 pattern, 2: random
    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            case (k % 6)
                0, 3, 5: return 1'b1;
                default: return 1'b0;
            endcase
        end
        return 1'($urandom % 2);
    endfunction

    task automatic run(input int sa, input int n, input int mode, input bit poke);
        int issued = 0;
        int acc = 0;
        int hs = -1;
        int first_v = -1;
        int k = 0;
        bit finished = 0;
        bit stalled = 0;
        bit ed;
        logic [DATA_WIDTH-1:0] held_d = '0;
        logic held_l = 1'b0;

        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = ADDR_BITS'(sa);
        len        = (ADDR_BITS+1)'(n);
        out_ready  = ready_for(mode, 0);
        while (!finished && k < 80) begin
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            if (poke && n > 0 && k == 2) begin
                start      = 1'b1;
                start_addr = ADDR_BITS'(sa + 3);
                len        = (ADDR_BITS+1)'(1);
            end
            out_ready = ready_for(mode, k);
            @(negedge clk);
            check("busy", 32'(busy), 32'(n > 0 && hs < 0));
            ed = (n == 0) ? (k == 1) : (hs >= 0 && k == hs + 1);
            check("done", 32'(done), 32'(ed));
            if (ed) finished = 1;
            if (n == 0) check("zero_len_valid", 32'(out_valid), 32'(0));
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'(1));
                check("stall_data", 32'(out_data), 32'(held_d));
                check("stall_last", 32'(out_last), 32'(held_l));
            end
            if (out_valid && first_v < 0) begin
                first_v = k;
                if (mode == 0) check("first_valid_cycle", 32'(k), 32'(3));
            end
            if (out_valid && out_ready) begin
                if (acc < n) begin
                    check("data", 32'(out_data), exp_word(sa + acc));
                    check("last", 32'(out_last), 32'(acc == n - 1));
                    if (acc == n - 1) begin
                        hs = k;
                        if (mode == 0) check("last_word_cycle", 32'(k), 32'(n + 2));
                    end
                    acc++;
                end else begin
                    check("extra_word", 32'(1), 32'(0));
                end
            end
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_l  = out_last;
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'((sa + issued) % RAM_DEPTH));
                issued++;
                check("issue_count", 32'(issued <= n), 32'(1));
                check("outstanding", 32'(issued - acc <= 2), 32'(1));
            end
        end
        if (!finished) check("timeout", 32'(0), 32'(1));
        check("word_count", 32'(acc), 32'(n));
        @(posedge clk); #1;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 32'(0));
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'(0));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_out_data"}, 32'(out_data), 32'(0));
        check({tag, "_out_last"}, 32'(out_last), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        int cnt;
        for (int a = 0; a < int'(RAM_DEPTH); a++) mem[a] = DATA_WIDTH'(8'h10 + a);
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        out_ready  = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run(2, 4, 0, 0);
        run(6, 4, 0, 0);
        run(0, 8, 0, 0);
        run(0, 5, 1, 0);
        run(5, 0, 0, 0);
        run(1, 6, 0, 1);
        run(4, 7, 1, 1);

        // Asynchronous reset in the middle of a transfer.
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = '0;
        len        = (ADDR_BITS+1)'(6);
        out_ready  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) cnt++;
        end
        check("rst_pre_words", 32'(cnt), 32'(2));
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'(0));
            check("post_rst_valid", 32'(out_valid), 32'(0));
        end
        run(3, 2, 0, 0);

        for (int i = 0; i < 25; i++) begin
            run(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)),
                int'($urandom_range(0, 2)), 1'($urandom % 3 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/weights_ram_reader.md
# weights_ram_reader

Read-side companion to the weights RAM write path. On a `start` pulse it issues sequential read addresses to a synchronous-read weights RAM (one-cycle read latency) from `start_addr` for `len` words, wrapping modulo `RAM_DEPTH`. It streams the returned words out on a valid/ready interface. A 2-entry output buffer with credit-based issue gives one word per cycle under no backpressure and loses no data under backpressure. It sits between the weights storage and the MAC datapath that consumes weights.

## Interface
- `RAM_DEPTH`, default 8: number of words in the weights RAM; power of two.
- `ADDR_BITS`, default 3: log2(`RAM_DEPTH`); width of addresses.
- `DATA_WIDTH`, default 8: weight word width.
- `clk` in, 1: single clock; all logic on rising edge.
- `rst` in, 1: reset; asynchronous, active-high.
- `start` in, 1: one-cycle request; sampled only when `busy`=0 and `done`=0.
- `start_addr` in, `ADDR_BITS`: first RAM address; sampled with `start`.
- `len` in, `ADDR_BITS`+1: word count, 0..`RAM_DEPTH`; sampled with `start`.
- `rd_en` out, 1: RAM read strobe.
- `rd_addr` out, `ADDR_BITS`: RAM read address, valid when `rd_en`=1.
- `rd_data` in, `DATA_WIDTH`: RAM data; valid in the cycle after `rd_en`.
- `out_valid` out, 1: `out_data` holds a word.
- `out_ready` in, 1: consumer accepts the word.
- `out_data` out, `DATA_WIDTH`: streamed weight.
- `out_last` out, 1: marks the final word of the transfer; qualified by `out_valid`.
- `busy` out, 1: a transfer is in progress.
- `done` out, 1: one-cycle pulse after the final word is accepted.

## Operation
- Reset values: `rd_en`, `rd_addr`, `out_valid`, `out_data`, `out_last`, `busy`, `done` are all 0. The buffer is emptied and all counters are cleared.
- States:
  - IDLE. `start` with `len`>0 goes to RUN. `start` with `len`=0 goes to FIN.
  - RUN. The block issues reads and streams words out. When the last word is accepted it goes to FIN.
  - FIN. `done`=1 for exactly one cycle, then the block returns to IDLE.
- Issue rule: `rd_en`=1 when all of the following hold:
  - the state is RUN;
  - the issued count is less than `len`;
  - occupancy + inflight − pop is less than 2.
- Terms used in the issue rule:
  - inflight is the `rd_en` value from the previous cycle.
  - pop is `out_valid` AND `out_ready` in the current cycle.
- Address generation: `rd_addr` starts at `start_addr` and increments by 1 per issued read, wrapping from `RAM_DEPTH`−1 to 0.
- Capture: `rd_data` is written into the buffer at the end of the cycle after `rd_en`. The buffer is FIFO ordered, depth 2.
- Output: `out_valid` is high whenever the buffer is non-empty, and `out_data` is the head entry.
- `out_last`=1 when the head entry is word number `len` of the transfer.
- Handshake:
  - A word transfers in any cycle with `out_valid` and `out_ready` both high.
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable and `out_valid` stays high.
- `busy`=1 from the cycle after `start` is accepted, through the cycle of the final handshake. It is 0 during FIN.
- A `start` while `busy` or `done` is high is ignored; it changes no state or output.
- `len` = `RAM_DEPTH` reads every address exactly once, including the wrap.
- Simultaneous push and pop on the buffer leaves occupancy unchanged.
- An asynchronous `rst` mid-transfer:
  - immediately forces all outputs to their reset values;
  - discards buffered and in-flight data;
  - produces no `done` pulse.

## Timing
- Cycle t: `start` is sampled high, with `len`>0.
- t+1: `rd_en`=1, `rd_addr`=`start_addr`, `busy`=1.
- t+2: `rd_data` is valid and is captured at the end of the cycle.
- t+3: first `out_valid`=1.
- With `out_ready` held high, reads issue every cycle from t+1 and output words appear every cycle from t+3.
- The last word of a transfer with `len`=N appears at t+N+2.
- `done` pulses in the cycle after the final handshake. With `out_ready` held high, that is t+N+3.
- `start` with `len`=0: `done`=1 at t+1, `busy` stays 0, and `rd_en` and `out_valid` are never asserted.
- Throughput under backpressure: at most 2 words are buffered or in flight. Issue resumes in the same cycle that a pop frees a slot.

## Test plan
- RAM model: `mem[a]` = 0x10 + `a`, read data returned one cycle after `rd_en`. Basic transfer:
  - Stimulus: `start_addr`=2, `len`=4, `out_ready`=1.
  - Required: `rd_addr` 2,3,4,5 on consecutive cycles; `out_data` 0x12,0x13,0x14,0x15 at t+3..t+6; `out_last` only on 0x15; `done` at t+7.
- Wrap:
  - Stimulus: `start_addr`=6, `len`=4.
  - Required: `out_data` sequence 0x16,0x17,0x10,0x11.
  - Also run `len`=8 from `start_addr`=0: all 8 words in address order, with `out_last` on 0x17.
- Backpressure:
  - Stimulus: `start_addr`=0, `len`=5, `out_ready` toggling 1,0,0,1,0,1,...
  - Required: words 0x10..0x14 delivered in order with no loss or duplication; `out_data` stable while stalled; never more than 2 reads outstanding beyond the consumed count.
- Zero length and ignored start:
  - `len`=0: `done` one cycle later; no `rd_en`; no `out_valid`.
  - `start` pulsed mid-transfer: no effect on the running sequence.
- Reset mid-transfer:
  - Stimulus: assert `rst` asynchronously after 2 words of a `len`=6 transfer.
  - Required: all outputs 0 immediately, no `done`.
  - A following `start`, `start_addr`=3, `len`=2, yields 0x13,0x14.
